ifu_axi_fetch: RTL
==================

Name: ifu_axi_fetch

Overview:
- Instruction-fetch bridge that sits directly upstream of the single-cycle CPU core.
- Serves the core's fetch handshake (if_valid / if_addr / if_ready / if_data_read) by issuing single-beat AXI4-Lite reads on a 64-bit instruction bus.
- Selects the 32-bit instruction from the returned beat and pulses if_ready for exactly one cycle per fetch.
- Lets the core stall on real memory latency instead of a zero-latency DPI read.

Parameters:
- ADDR_WIDTH, 64, fetch/bus address width
- DATA_WIDTH, 64, AXI read data width (fixed at 64)
- INST_WIDTH, 32, instruction width

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  core fetch request (held high by the core)
- if_addr  in  ADDR_WIDTH  fetch PC, stable until if_ready
- if_ready  out  1  one-cycle pulse: if_data_read valid
- if_data_read  out  INST_WIDTH  fetched instruction
- if_err  out  1  with if_ready: access fault or misaligned PC
- flush  in  1  invalidate line buffer (fence.i); no effect without macro
- araddr  out  ADDR_WIDTH  8-byte-aligned read address
- arvalid  out  1  AR valid
- arready  in  1  AR ready
- arprot  out  3  constant 3'b100 (instruction, secure, unprivileged)
- rdata  in  DATA_WIDTH  read beat
- rresp  in  2  read response
- rvalid  in  1  R valid
- rready  out  1  R ready

Behaviour:
- Reset: state=IDLE; if_ready, if_err, arvalid, rready = 0; if_data_read = 0; araddr = 0; internal address latch = 0.
- FSM states: IDLE, AR, R, RESP.
- IDLE:
  - if_valid=1 and if_addr[1:0]!=0: latch address, go RESP with err=1; no bus traffic.
  - Otherwise if_valid=1: latch if_addr, araddr = {if_addr[ADDR_WIDTH-1:3],3'b0}, go AR.
- AR: arvalid=1. Address is stable while waiting. arvalid=1 and arready=1 -> R.
- R: rready=1. rvalid=1 -> capture beat, err = (rresp[1]==1), i.e. SLVERR/DECERR. OKAY and EXOKAY are not errors. Go RESP.
- RESP:
  - if_ready=1 for this cycle only.
  - if_data_read = addr[2] ? beat[63:32] : beat[31:0]. On error the data is 32'h0000_0013 (nop).
  - if_err = err. Next state IDLE.
- if_data_read holds its last value outside RESP.
- Minimum miss latency: request seen in IDLE at cycle 0, arready=1 at cycle 1, rvalid=1 at cycle 2, if_ready=1 at cycle 3. One bubble (IDLE) between consecutive fetches.
- At most one outstanding AR. rready is never asserted outside R.
- rvalid in AR or IDLE: not consumed. The slave must not issue it.
- if_addr changing mid-fetch is ignored; the latched address is used.
- Reset mid-transaction: the FSM returns to IDLE next edge and arvalid/rready drop. The bus slave shares the same rst.

Optional Feature:
- Macro: IFU_LINE_BUF_EN.
- With the macro: a one-entry buffer holds the tag if_addr[ADDR_WIDTH-1:3], the 64-bit beat, and a valid bit.
  - Filled on every error-free R completion.
  - In IDLE, a request whose tag matches a valid buffer goes straight to RESP (hit latency 1 cycle, no AR issued).
  - Cleared by rst, by flush (flush has priority over a same-cycle fill), and by any error response.
- Without the macro: no buffer, every fetch goes to the bus, and flush is ignored.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE/AR/R/RESP, 2 bits)
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR constants
  - ARPROT_IFETCH = 3'b100
  - NOP_INST = 32'h00000013
- Optional sub-module ifu_line_buf: tag/data/valid registers, hit compare, fill/flush logic; instantiated only under IFU_LINE_BUF_EN.

Test Plan:
- Zero-wait fetch, if_addr=0x8000_0004, rdata=0x00A0_0093_0000_0013, OKAY -> araddr=0x8000_0000, if_ready at cycle 3, if_data_read=0x00A00093, if_err=0.
- arready delayed 5 cycles, then rvalid delayed 3 cycles -> arvalid held 6 cycles with araddr stable, rready high only in R, exactly one if_ready pulse.
- rresp=2'b10 for addr 0x8000_0000 -> if_ready with if_err=1, if_data_read=0x00000013; the next fetch of the same line reissues AR.
- Misaligned if_addr=0x8000_0002 -> if_ready one cycle after the request, if_err=1, arvalid never asserted.
- Sync rst asserted while in R -> next cycle arvalid=0, rready=0, if_ready=0, state IDLE; the fetch after reset completes normally.
- IFU_LINE_BUF_EN: fetch 0x8000_0000 then 0x8000_0004 -> second fetch returns the upper word in 1 cycle with no AR. Assert flush, fetch 0x8000_0000 again -> AR reissued.

Source files
------------

// File: rtl/ifu_axi_fetch_pkg.sv
// Shared types and constants for the AXI4-Lite instruction-fetch bridge.
package ifu_axi_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0]  AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0]  AXI_RESP_DECERR = 2'b11;
  localparam logic [2:0]  ARPROT_IFETCH   = 3'b100;
  localparam logic [31:0] NOP_INST        = 32'h0000_0013;

  function automatic logic [31:0] pick_word(
    input logic        hi,
    input logic [63:0] beat
  );
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/ifu_axi_fetch_line_buf.sv
// One-entry 64-bit line buffer for the fetch bridge.
// Only instantiated when IFU_LINE_BUF_EN is defined.
module ifu_line_buf #(
  parameter int TAG_WIDTH  = 61,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clear,
  input  logic                  fill,
  input  logic [TAG_WIDTH-1:0]  fill_tag,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic                  hit,
  output logic [DATA_WIDTH-1:0] data
);

  logic                 valid;
  logic [TAG_WIDTH-1:0] tag;

  // Invalidation wins over a fill landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (flush || clear) begin
      valid <= 1'b0;
    end else if (fill) begin
      valid <= 1'b1;
      tag   <= fill_tag;
      data  <= fill_data;
    end
  end

  assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/ifu_axi_fetch.sv
// Fetch bridge: core fetch handshake -> single-beat AXI4-Lite reads.
// Optional one-line buffer enabled by defining IFU_LINE_BUF_EN.
module ifu_axi_fetch
  import ifu_axi_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [INST_WIDTH-1:0] if_data_read,
  output logic                  if_err,
  input  logic                  flush,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [2:0]            arprot,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  hit;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  r_done;
  logic                  r_err;
  logic                  unused_bits;

  assign arprot = ARPROT_IFETCH;
  assign araddr = {addr[ADDR_WIDTH-1:3], 3'b000};
  assign r_done = (state == R) && rvalid;
  assign r_err  = rresp[1];

`ifdef IFU_LINE_BUF_EN
  ifu_line_buf #(
    .TAG_WIDTH  (ADDR_WIDTH - 3),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .clear      (r_done && r_err),
    .fill       (r_done && !r_err),
    .fill_tag   (addr[ADDR_WIDTH-1:3]),
    .fill_data  (rdata),
    .lookup_tag (if_addr[ADDR_WIDTH-1:3]),
    .hit        (hit),
    .data       (buf_data)
  );
`else
  assign hit      = 1'b0;
  assign buf_data = '0;
`endif

  assign unused_bits = ^{flush, addr[1:0], rresp[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      arvalid      <= 1'b0;
      rready       <= 1'b0;
      if_ready     <= 1'b0;
      if_err       <= 1'b0;
      if_data_read <= '0;
    end else begin
      if_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (if_valid) begin
            addr <= if_addr;
            if (if_addr[1:0] != 2'b00) begin
              state        <= RESP;
              if_ready     <= 1'b1;
              if_err       <= 1'b1;
              if_data_read <= NOP_INST;
            end else if (hit) begin
              state        <= RESP;
              if_ready     <= 1'b1;
              if_err       <= 1'b0;
              if_data_read <= pick_word(if_addr[2], buf_data);
            end else begin
              state   <= AR;
              arvalid <= 1'b1;
            end
          end
        end
        AR: begin
          if (arready) begin
            state   <= R;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        R: begin
          if (rvalid) begin
            state    <= RESP;
            rready   <= 1'b0;
            if_ready <= 1'b1;
            if_err   <= r_err;
            if_data_read <= r_err ? NOP_INST
                                  : pick_word(addr[2], rdata);
          end
        end
        RESP: begin
          state  <= IDLE;
          if_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
